// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access stage: load/store codes,
// FSM states and byte-lane enable patterns.
package mem_access_pkg;

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LW   = 3'b011;
   localparam logic [2:0] LD_LBU  = 3'b100;
   localparam logic [2:0] LD_LHU  = 3'b101;

   localparam logic [2:0] ST_NONE = 3'b000;
   localparam logic [2:0] ST_SB   = 3'b001;
   localparam logic [2:0] ST_SH   = 3'b010;
   localparam logic [2:0] ST_SW   = 3'b011;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } mau_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it according to the load code.
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_ld_code,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
   end

   always_comb begin
      case (i_ld_code)
         LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         LD_LH:   o_data = {{16{w_half[15]}}, w_half};
         LD_LBU:  o_data = {24'd0, w_byte};
         LD_LHU:  o_data = {16'd0, w_half};
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues word-wide data-memory requests and stalls
// the pipeline until done. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [2:0]        MEM_READ,
   input  logic [2:0]        MEM_WRITE,
   input  logic [ADDR_W-1:0] ALU_RESULT,
   input  logic [DATA_W-1:0] OUT2,
   input  logic              DMEM_READY,
   input  logic [DATA_W-1:0] DMEM_RDATA,
   output logic              DMEM_READ,
   output logic              DMEM_WRITE,
   output logic [ADDR_W-1:0] DMEM_ADDR,
   output logic [DATA_W-1:0] DMEM_WDATA,
   output logic [3:0]        DMEM_BYTE_EN,
   output logic [DATA_W-1:0] LOAD_DATA,
   output logic              BUSY_WAIT,
   output logic              MISALIGNED
);

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   mau_state_e r_state, w_state_nxt;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_be;
   logic [1:0]        r_addr_lo;
   logic [2:0]        r_ld_code;
   logic              r_is_store;
   logic [DATA_W-1:0] r_load_data;

   logic              w_st_valid, w_ld_valid, w_is_word, w_is_half;
   logic              w_mis_raw, w_misaligned, w_op_ok;
   logic [1:0]        w_addr_lo;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_fmt;
   logic              w_busy, w_accept, w_complete;

   // A store wins over a simultaneous load.
   assign w_st_valid = MEM_WRITE inside {ST_SB, ST_SH, ST_SW};
   assign w_ld_valid = !w_st_valid && (MEM_READ inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU});
   assign w_is_word  = w_st_valid ? (MEM_WRITE == ST_SW) : (MEM_READ == LD_LW);
   assign w_is_half  = w_st_valid ? (MEM_WRITE == ST_SH)
                                  : (MEM_READ == LD_LH || MEM_READ == LD_LHU);

   assign w_mis_raw    = (w_st_valid || w_ld_valid) &&
                         ((w_is_word && ALU_RESULT[1:0] != 2'b00) || (w_is_half && ALU_RESULT[0]));
   assign w_misaligned = TRAP_EN && w_mis_raw;
   assign w_op_ok      = (w_st_valid || w_ld_valid) && !w_misaligned;

   // Without the trap, offending low bits are forced to natural alignment.
   assign w_addr_lo = w_is_word ? 2'b00 : (w_is_half ? {ALU_RESULT[1], 1'b0} : ALU_RESULT[1:0]);
   assign w_be      = w_is_word ? BE_WORD : (w_is_half ? (BE_HALF << w_addr_lo) : (BE_BYTE << w_addr_lo));
   assign w_wdata   = w_is_word ? OUT2 : (w_is_half ? {2{OUT2[15:0]}} : {4{OUT2[7:0]}});

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_op_ok) begin
               w_busy      = 1'b1;
               w_accept    = 1'b1;
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_busy = 1'b1;
            if (DMEM_READY) begin
               w_complete  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   mem_load_align u_load_align (
      .i_word    (DMEM_RDATA),
      .i_addr_lo (r_addr_lo),
      .i_ld_code (r_ld_code),
      .o_data    (w_fmt)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= BE_NONE;
         r_addr_lo   <= 2'b00;
         r_ld_code   <= LD_NONE;
         r_is_store  <= 1'b0;
         r_load_data <= '0;
      end else begin
         if (w_accept) begin
            r_addr     <= {ALU_RESULT[ADDR_W-1:2], 2'b00};
            r_wdata    <= w_wdata;
            r_be       <= w_be;
            r_addr_lo  <= w_addr_lo;
            r_ld_code  <= MEM_READ;
            r_is_store <= w_st_valid;
         end
         if (w_complete && !r_is_store)
            r_load_data <= w_fmt;
         else if (r_state == S_IDLE && w_misaligned && w_ld_valid)
            r_load_data <= '0;
      end
   end

   // Reset gates the combinational outputs so an abandoned request drops at once.
   assign DMEM_READ    = (r_state == S_ACCESS) && !r_is_store;
   assign DMEM_WRITE   = (r_state == S_ACCESS) && r_is_store;
   assign DMEM_ADDR    = r_addr;
   assign DMEM_WDATA   = r_wdata;
   assign DMEM_BYTE_EN = r_be;
   assign LOAD_DATA    = r_load_data;
   assign BUSY_WAIT    = w_busy && !RESET;
   assign MISALIGNED   = w_misaligned && !RESET;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic [2:0]  MEM_READ, MEM_WRITE;
   logic [31:0] ALU_RESULT, OUT2, DMEM_RDATA;
   logic        DMEM_READY;
   logic        DMEM_READ, DMEM_WRITE, BUSY_WAIT, MISALIGNED;
   logic [31:0] DMEM_ADDR, DMEM_WDATA, LOAD_DATA;
   logic [3:0]  DMEM_BYTE_EN;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .ALU_RESULT(ALU_RESULT), .OUT2(OUT2), .DMEM_READY(DMEM_READY), .DMEM_RDATA(DMEM_RDATA),
      .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN), .LOAD_DATA(LOAD_DATA),
      .BUSY_WAIT(BUSY_WAIT), .MISALIGNED(MISALIGNED)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] phys    [64];   // memory as actually written by the DUT
   logic [31:0] exp_mem [64];   // memory as the model says it must be
   logic [31:0] model_ld;

   bit          exp_chk = 1'b0;
   logic        exp_busy, exp_rd, exp_wr, exp_mis;
   logic [31:0] exp_addr, exp_wdata, exp_ld;
   logic [3:0]  exp_be;

   int          busy_cnt;
   bit          seen_rd, seen_wr;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [2:0] code);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * lo));
      h = 16'(w >> (16 * lo[1]));
      case (code)
         3'd1:    return {{24{b[7]}}, b};
         3'd2:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return w;
      endcase
   endfunction

   // Single compare process plus bus observation.
   always @(negedge CLK) begin
      if (BUSY_WAIT) busy_cnt++;
      if (DMEM_READ) seen_rd = 1'b1;
      if (DMEM_READ || DMEM_WRITE) last_addr = DMEM_ADDR;
      if (DMEM_WRITE) begin
         seen_wr    = 1'b1;
         last_wdata = DMEM_WDATA;
         last_be    = DMEM_BYTE_EN;
         if (DMEM_READY)
            for (int k = 0; k < 4; k++)
               if (DMEM_BYTE_EN[k]) phys[DMEM_ADDR[7:2]][8*k +: 8] = DMEM_WDATA[8*k +: 8];
      end
      if (exp_chk) begin
         check("busy_wait", {31'd0, BUSY_WAIT}, {31'd0, exp_busy});
         check("dmem_read", {31'd0, DMEM_READ}, {31'd0, exp_rd});
         check("dmem_write", {31'd0, DMEM_WRITE}, {31'd0, exp_wr});
         check("misaligned", {31'd0, MISALIGNED}, {31'd0, exp_mis});
         check("load_data", LOAD_DATA, exp_ld);
         if (exp_rd || exp_wr) check("dmem_addr", DMEM_ADDR, exp_addr);
         if (exp_wr) begin
            check("dmem_wdata", DMEM_WDATA, exp_wdata);
            check("dmem_byte_en", {28'd0, DMEM_BYTE_EN}, {28'd0, exp_be});
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Presents one op for its whole life (entered and left 1 time unit after a rising edge).
   task automatic run_op(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] data, input int lat);
      bit          st, ld, half, word, mis;
      logic [1:0]  lo;
      logic [31:0] ea, wd;
      logic [3:0]  be;
      st   = (wr == 3'd1 || wr == 3'd2 || wr == 3'd3);
      ld   = !st && (rd >= 3'd1 && rd <= 3'd5);
      half = st ? (wr == 3'd2) : (rd == 3'd2 || rd == 3'd5);
      word = st ? (wr == 3'd3) : (rd == 3'd3);
      mis  = (st || ld) && ((word && addr[1:0] != 2'b00) || (half && addr[0]));
      lo   = word ? 2'b00 : (half ? {addr[1], 1'b0} : addr[1:0]);
      ea   = {addr[31:2], lo};
      be   = word ? 4'b1111 : (half ? (4'b0011 << lo) : (4'b0001 << lo));
      wd   = word ? data : (half ? {2{data[15:0]}} : {4{data[7:0]}});

      MEM_READ   = rd;
      MEM_WRITE  = wr;
      ALU_RESULT = addr;
      OUT2       = data;
      DMEM_READY = 1'($urandom_range(0, 1));
      DMEM_RDATA = $urandom;
      exp_chk = 1'b1;
      exp_rd  = 1'b0;
      exp_wr  = 1'b0;
      exp_mis = 1'b0;
      exp_ld  = model_ld;

      if (!(st || ld)) begin
         exp_busy = 1'b0;
         step();
         return;
      end
      if (TRAP && mis) begin
         exp_busy = 1'b0;
         exp_mis  = 1'b1;
         step();
         if (ld) model_ld = 32'd0;
         exp_mis = 1'b0;
         return;
      end

      exp_busy = 1'b1;
      step();
      for (int i = 0; i <= lat; i++) begin
         DMEM_READY = (i == lat);
         DMEM_RDATA = phys[DMEM_ADDR[7:2]];
         exp_rd    = ld;
         exp_wr    = st;
         exp_addr  = {ea[31:2], 2'b00};
         exp_wdata = wd;
         exp_be    = be;
         step();
      end

      if (st)
         for (int k = 0; k < 4; k++)
            if (be[k]) exp_mem[ea[7:2]][8*k +: 8] = wd[8*k +: 8];
      if (ld) model_ld = fmt_load(exp_mem[ea[7:2]], lo, rd);

      exp_rd     = 1'b0;
      exp_wr     = 1'b0;
      exp_busy   = 1'b0;
      exp_ld     = model_ld;
      DMEM_READY = 1'($urandom_range(0, 1));
      step();
   endtask

   task automatic clear_seen();
      seen_rd  = 1'b0;
      seen_wr  = 1'b0;
      busy_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ld_before;
      RESET      = 1'b1;
      MEM_READ   = 3'd0;
      MEM_WRITE  = 3'd0;
      ALU_RESULT = 32'd0;
      OUT2       = 32'd0;
      DMEM_READY = 1'b0;
      DMEM_RDATA = 32'd0;
      model_ld   = 32'd0;
      for (int i = 0; i < 64; i++) begin
         phys[i]    = $urandom;
         exp_mem[i] = phys[i];
      end
      clear_seen();

      #12;
      check("rst_dmem_read", {31'd0, DMEM_READ}, 32'd0);
      check("rst_dmem_write", {31'd0, DMEM_WRITE}, 32'd0);
      check("rst_busy_wait", {31'd0, BUSY_WAIT}, 32'd0);
      check("rst_misaligned", {31'd0, MISALIGNED}, 32'd0);
      check("rst_dmem_addr", DMEM_ADDR, 32'd0);
      check("rst_dmem_wdata", DMEM_WDATA, 32'd0);
      check("rst_byte_en", {28'd0, DMEM_BYTE_EN}, 32'd0);
      check("rst_load_data", LOAD_DATA, 32'd0);
      step();
      RESET = 1'b0;

      // LW with one wait state.
      phys[4] = 32'hDEAD_BEEF;
      exp_mem[4] = 32'hDEAD_BEEF;
      clear_seen();
      run_op(3'd3, 3'd0, 32'h0000_0010, 32'd0, 1);
      check("lw_busy_cycles", busy_cnt, 32'd3);
      check("lw_load_data", LOAD_DATA, 32'hDEAD_BEEF);
      check("lw_dmem_addr", DMEM_ADDR, 32'h0000_0010);

      // Byte/halfword extraction and extension.
      phys[4] = 32'h80FF_7F01;
      exp_mem[4] = 32'h80FF_7F01;
      run_op(3'd1, 3'd0, 32'h0000_0013, 32'd0, 0);
      check("lb_load_data", LOAD_DATA, 32'hFFFF_FF80);
      run_op(3'd4, 3'd0, 32'h0000_0013, 32'd0, 2);
      check("lbu_load_data", LOAD_DATA, 32'h0000_0080);
      run_op(3'd2, 3'd0, 32'h0000_0012, 32'd0, 0);
      check("lh_load_data", LOAD_DATA, 32'hFFFF_80FF);

      // Store lane replication and byte enables.
      clear_seen();
      run_op(3'd0, 3'd1, 32'h0000_0021, 32'h1234_56AB, 0);
      check("sb_write_seen", {31'd0, seen_wr}, 32'd1);
      check("sb_addr", last_addr, 32'h0000_0020);
      check("sb_wdata", last_wdata, 32'hABAB_ABAB);
      check("sb_byte_en", {28'd0, last_be}, 32'h0000_0002);
      check("sb_load_kept", LOAD_DATA, 32'hFFFF_80FF);
      run_op(3'd0, 3'd2, 32'h0000_0022, 32'h1234_56AB, 1);
      check("sh_wdata", last_wdata, 32'h56AB_56AB);
      check("sh_byte_en", {28'd0, last_be}, 32'h0000_000C);

      // Misaligned LW at 0x06.
      phys[1] = 32'h0BAD_F00D;
      exp_mem[1] = 32'h0BAD_F00D;
      clear_seen();
      run_op(3'd3, 3'd0, 32'h0000_0006, 32'd0, 0);
      if (TRAP) begin
         check("mis_no_read", {31'd0, seen_rd}, 32'd0);
         check("mis_busy_cycles", busy_cnt, 32'd0);
         check("mis_load_zero", LOAD_DATA, 32'd0);
         ld_before = 32'd0;
      end else begin
         check("mis_read_seen", {31'd0, seen_rd}, 32'd1);
         check("mis_aligned_addr", last_addr, 32'h0000_0004);
         check("mis_load_data", LOAD_DATA, 32'h0BAD_F00D);
         ld_before = 32'h0BAD_F00D;
      end

      // Load and store together: only the store happens.
      clear_seen();
      run_op(3'd3, 3'd3, 32'h0000_0050, 32'hCAFE_F00D, 1);
      check("both_no_read", {31'd0, seen_rd}, 32'd0);
      check("both_write_seen", {31'd0, seen_wr}, 32'd1);
      check("both_load_kept", LOAD_DATA, ld_before);
      check("both_mem_written", phys[20], 32'hCAFE_F00D);

      // Reset in the middle of a SW access.
      exp_chk    = 1'b0;
      MEM_READ   = 3'd0;
      MEM_WRITE  = 3'd3;
      ALU_RESULT = 32'h0000_0040;
      OUT2       = 32'h5566_7788;
      DMEM_READY = 1'b0;
      step();
      check("rst_mid_write_on", {31'd0, DMEM_WRITE}, 32'd1);
      #2 RESET = 1'b1;
      #1;
      check("rst_mid_write_off", {31'd0, DMEM_WRITE}, 32'd0);
      check("rst_mid_busy_off", {31'd0, BUSY_WAIT}, 32'd0);
      check("rst_mid_read_off", {31'd0, DMEM_READ}, 32'd0);
      step();
      RESET    = 1'b0;
      model_ld = 32'd0;
      clear_seen();
      run_op(3'd0, 3'd3, 32'h0000_0040, 32'h5566_7788, 0);
      check("rst_retry_written", phys[16], 32'h5566_7788);
      check("rst_retry_busy_cycles", busy_cnt, 32'd2);

      // Randomized traffic, including idle ops, invalid codes and misaligned addresses.
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  rd, wr;
         logic [31:0] a;
         rd = 3'($urandom_range(0, 7));
         wr = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         a  = $urandom;
         run_op(rd, wr, a, $urandom, int'($urandom_range(0, 3)));
      end
      exp_chk = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
